// File: rtl/sdc_dat_bus_sched.sv
// sdc_dat_bus_sched
//   Schedules the shared bidirectional SD DAT bus between a block-write
//   requester and a block-read requester. Owns the pad output enable and
//   inserts released turnaround cycles around every driven burst.
//   Writes: start bit, BLK_NIBBLES data nibbles, end bit.
//   Reads:  wait for start bit, capture BLK_NIBBLES nibbles, check end bit.
//
// Optional feature: define SDC_DAT_TIMEOUT_EN to bound the read start-bit
//   wait to RD_TIMEOUT cycles (timeout pulse). Undefined: wait forever,
//   timeout tied low.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   wr_req       level, request one write block
//   rd_req       level, request one read block
//   wr_data      FWFT write nibble from the source
//   wr_data_rd   pop strobe (combinational); source advances after the edge
//   rd_data      captured read nibble
//   rd_data_vld  one-cycle strobe qualifying rd_data
//   dat_in       DAT bus as seen at the pad
//   dat_out      registered bus drive value
//   dat_oe       registered pad drive enable (1 = drive)
//   busy         high whenever not idle
//   done         one-cycle pulse at the end of a transfer
//   end_err      pulses with done when the read end bit is not all ones
//   timeout      one-cycle pulse when the read start bit never arrives
module sdc_dat_bus_sched #(
    parameter int unsigned DAT_W       = 4,
    parameter int unsigned BLK_NIBBLES = 1024,
    parameter int unsigned TURN_CYC    = 2,
    parameter int unsigned RD_TIMEOUT  = 1023
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_req,
    input  logic             rd_req,
    input  logic [DAT_W-1:0] wr_data,
    output logic             wr_data_rd,
    output logic [DAT_W-1:0] rd_data,
    output logic             rd_data_vld,
    input  logic [DAT_W-1:0] dat_in,
    output logic [DAT_W-1:0] dat_out,
    output logic             dat_oe,
    output logic             busy,
    output logic             done,
    output logic             end_err,
    output logic             timeout
);

    localparam int unsigned MAX_AB  = (BLK_NIBBLES > RD_TIMEOUT + 1) ? BLK_NIBBLES : RD_TIMEOUT + 1;
    localparam int unsigned CNT_MAX = (MAX_AB > TURN_CYC) ? MAX_AB : TURN_CYC;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'(TURN_CYC - 1);
    localparam logic [CNT_W-1:0] BLK_LAST  = CNT_W'(BLK_NIBBLES - 1);
`ifdef SDC_DAT_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(RD_TIMEOUT - 1);
`endif

    typedef enum logic [3:0] {
        IDLE, W_TURN, W_START, W_DATA, W_END, W_REL, R_WAIT, R_DATA, R_END
    } state_t;

    typedef enum logic {
        GRANT_READ, GRANT_WRITE
    } grant_t;

    state_t            state_q, state_d;
    grant_t            last_grant_q, last_grant_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              cnt_en;
    logic              timeout_hit;

    logic              dat_oe_q, dat_oe_d;
    logic [DAT_W-1:0]  dat_out_q, dat_out_d;
    logic [DAT_W-1:0]  rd_data_q, rd_data_d;
    logic              rd_data_vld_q, rd_data_vld_d;
    logic              done_q, done_d;
    logic              end_err_q, end_err_d;
    logic              timeout_q, timeout_d;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_READ;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        timeout_hit  = 1'b0;
        cnt_en       = 1'b1;

        unique case (state_q)
            IDLE: begin
                cnt_en = 1'b0;
                // Both requesting: alternate against the previous grant.
                if (wr_req && (!rd_req || last_grant_q == GRANT_READ)) begin
                    state_d      = W_TURN;
                    last_grant_d = GRANT_WRITE;
                end else if (rd_req) begin
                    state_d      = R_WAIT;
                    last_grant_d = GRANT_READ;
                end
            end
            W_TURN:  if (cnt_q == TURN_LAST) state_d = W_START;
            W_START: state_d = W_DATA;
            W_DATA:  if (cnt_q == BLK_LAST) state_d = W_END;
            W_END:   state_d = W_REL;
            W_REL:   if (cnt_q == TURN_LAST) state_d = IDLE;
            R_WAIT: begin
                if (!dat_in[0]) begin
                    state_d = R_DATA;
                end
`ifdef SDC_DAT_TIMEOUT_EN
                else if (cnt_q == TO_LAST) begin
                    state_d     = IDLE;
                    timeout_hit = 1'b1;
                end
`else
                // Unbounded wait: freeze the counter so it cannot wrap.
                cnt_en = 1'b0;
`endif
            end
            R_DATA:  if (cnt_q == BLK_LAST) state_d = R_END;
            R_END:   state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Counter restarts on every state entry.
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (cnt_en) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        busy          = (state_q != IDLE);
        wr_data_rd    = (state_q == W_START) || (state_q == W_DATA && cnt_q != BLK_LAST);

        // Pad drive is registered from the next state so it lines up with
        // the state it belongs to.
        dat_oe_d      = (state_d == W_START) || (state_d == W_DATA) || (state_d == W_END);
        dat_out_d     = '1;
        if (state_d == W_START) begin
            dat_out_d = '0;
        end else if (state_d == W_DATA) begin
            dat_out_d = wr_data;
        end

        rd_data_d     = rd_data_q;
        rd_data_vld_d = 1'b0;
        if (state_q == R_DATA) begin
            rd_data_d     = dat_in;
            rd_data_vld_d = 1'b1;
        end

        done_d    = (state_q == W_REL && state_d == IDLE) || (state_q == R_END) || timeout_hit;
        end_err_d = (state_q == R_END) && (dat_in != '1);
        timeout_d = timeout_hit;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dat_oe_q      <= 1'b0;
            dat_out_q     <= '1;
            rd_data_q     <= '0;
            rd_data_vld_q <= 1'b0;
            done_q        <= 1'b0;
            end_err_q     <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            dat_oe_q      <= dat_oe_d;
            dat_out_q     <= dat_out_d;
            rd_data_q     <= rd_data_d;
            rd_data_vld_q <= rd_data_vld_d;
            done_q        <= done_d;
            end_err_q     <= end_err_d;
            timeout_q     <= timeout_d;
        end
    end

    assign dat_oe      = dat_oe_q;
    assign dat_out     = dat_out_q;
    assign rd_data     = rd_data_q;
    assign rd_data_vld = rd_data_vld_q;
    assign done        = done_q;
    assign end_err     = end_err_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_sdc_dat_bus_sched.sv
// tb_sdc_dat_bus_sched
//   Randomized self-checking bench for sdc_dat_bus_sched with BLK_NIBBLES=4,
//   TURN_CYC=2, RD_TIMEOUT=16. Expected bus traces are derived per transfer
//   from the cycle offsets of each framing phase.
module tb_sdc_dat_bus_sched;

    localparam int T    = 2;
    localparam int BLK  = 4;
    localparam int RDTO = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_req;
    logic       rd_req;
    logic [3:0] wr_data;
    logic       wr_data_rd;
    logic [3:0] rd_data;
    logic       rd_data_vld;
    logic [3:0] dat_in;
    logic [3:0] dat_out;
    logic       dat_oe;
    logic       busy;
    logic       done;
    logic       end_err;
    logic       timeout;

    always #5 clk = ~clk;

    sdc_dat_bus_sched #(
        .DAT_W      (4),
        .BLK_NIBBLES(BLK),
        .TURN_CYC   (T),
        .RD_TIMEOUT (RDTO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_req     (wr_req),
        .rd_req     (rd_req),
        .wr_data    (wr_data),
        .wr_data_rd (wr_data_rd),
        .rd_data    (rd_data),
        .rd_data_vld(rd_data_vld),
        .dat_in     (dat_in),
        .dat_out    (dat_out),
        .dat_oe     (dat_oe),
        .busy       (busy),
        .done       (done),
        .end_err    (end_err),
        .timeout    (timeout)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Packed snapshot: {0, oe, out[3:0], busy, pop, vld, rdata[3:0], done, err, to}
    function automatic logic [31:0] obs(input logic m);
        return {16'h0, 1'b0, dat_oe, dat_out, busy, wr_data_rd, rd_data_vld,
                rd_data & {4{m}}, done, end_err, timeout};
    endfunction

    function automatic logic [31:0] expv(input logic oe, input logic [3:0] out, input logic bsy,
                                         input logic pop, input logic vld, input logic [3:0] rd,
                                         input logic dn, input logic er, input logic to);
        return {16'h0, 1'b0, oe, out, bsy, pop, vld, rd, dn, er, to};
    endfunction

    // Write transfer: call at a negedge while idle with the request already set.
    task automatic run_write(input string tag, input bit keep, input int abort_at,
                             input logic [15:0] data);
        logic [3:0] q[$];
        logic       pend;
        int         pops;
        int         last;
        logic       e_oe, e_bsy, e_pop, e_dn;
        logic [3:0] e_out;
        for (int k = 0; k < BLK; k++) q.push_back(data[k*4 +: 4]);
        wr_data = q[0];
        pend    = 1'b0;
        pops    = 0;
        last    = 2*T + BLK + 2;
        for (int i = 0; i <= last; i++) begin
            @(negedge clk);
            // The source advances only after the edge that saw the pop.
            if (pend) begin
                void'(q.pop_front());
                wr_data = (q.size() > 0) ? q[0] : 4'h0;
            end
            e_oe = 1'b0; e_out = 4'hF; e_bsy = 1'b1; e_pop = 1'b0; e_dn = 1'b0;
            if (i == T) begin
                e_oe = 1'b1; e_out = 4'h0; e_pop = 1'b1;
            end else if (i > T && i <= T + BLK) begin
                e_oe  = 1'b1;
                e_out = data[(i-T-1)*4 +: 4];
                e_pop = (i - T - 1 < BLK - 1);
            end else if (i == T + BLK + 1) begin
                e_oe = 1'b1;
            end
            if (i == last) begin
                e_bsy = 1'b0; e_dn = 1'b1;
            end
            chk($sformatf("%s[%0d]", tag, i), obs(1'b0),
                expv(e_oe, e_out, e_bsy, e_pop, 1'b0, 4'h0, e_dn, 1'b0, 1'b0));
            pend = wr_data_rd;
            if (wr_data_rd) pops++;
            if (i == 0 && !keep) begin
                wr_req = 1'b0; rd_req = 1'b0;
            end
            if (i == abort_at) begin
                reset = 1'b1;
                return;
            end
        end
        chk({tag, "_pops"}, pops, BLK);
    endtask

    // Read transfer: w idle-bus cycles precede the start bit.
    task automatic run_read(input string tag, input bit keep, input int w,
                            input logic [15:0] data, input logic [3:0] endn, input bit noisy);
        int          last;
        logic        e_vld, e_dn;
        logic [3:0]  e_rd;
        logic [31:0] r;
        last = w + 2 + BLK;
        for (int i = 0; i <= last; i++) begin
            @(negedge clk);
            e_vld = (i >= w + 2) && (i <= w + 1 + BLK);
            e_rd  = e_vld ? data[(i-w-2)*4 +: 4] : 4'h0;
            e_dn  = (i == last);
            chk($sformatf("%s[%0d]", tag, i), obs(e_vld),
                expv(1'b0, 4'hF, i < last, 1'b0, e_vld, e_rd, e_dn, e_dn && endn != 4'hF, 1'b0));
            r = $urandom;
            if (i < w)                  dat_in = noisy ? {r[2:0], 1'b1} : 4'hF;
            else if (i == w)            dat_in = noisy ? {r[2:0], 1'b0} : 4'h0;
            else if (i <= w + BLK)      dat_in = data[(i-w-1)*4 +: 4];
            else if (i == w + 1 + BLK)  dat_in = endn;
            else                        dat_in = 4'hF;
            if (i == 0 && !keep) begin
                wr_req = 1'b0; rd_req = 1'b0;
            end
        end
    endtask

    task automatic run_rd_timeout();
        dat_in = 4'hF;
`ifdef SDC_DAT_TIMEOUT_EN
        for (int i = 0; i <= RDTO; i++) begin
            @(negedge clk);
            chk($sformatf("tmo[%0d]", i), obs(1'b0),
                expv(1'b0, 4'hF, i < RDTO, 1'b0, 1'b0, 4'h0, i == RDTO, 1'b0, i == RDTO));
            if (i == 0) rd_req = 1'b0;
        end
`else
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            chk($sformatf("wait[%0d]", i), obs(1'b0),
                expv(1'b0, 4'hF, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0));
            if (i == 0) rd_req = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        chk("wait_rst", obs(1'b0), expv(1'b0, 4'hF, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0));
        reset = 1'b0;
`endif
    endtask

    // Released-gap monitor between driven bursts.
    int   gap    = 0;
    logic prev   = 1'b0;
    logic seen   = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            seen = 1'b0; gap = 0;
        end else if (dat_oe) begin
            if (!prev && seen) chk("oe_gap", 32'(gap >= T), 32'd1);
            seen = 1'b1; gap = 0;
        end else begin
            gap++;
        end
        prev = dat_oe;
    end

    initial begin : main
        logic        last_wr;
        logic        grant_wr;
        logic [1:0]  r2;
        logic [3:0]  endn;
        reset   = 1'b1;
        wr_req  = 1'b0;
        rd_req  = 1'b0;
        wr_data = 4'h0;
        dat_in  = 4'hF;
        repeat (3) @(negedge clk);
        chk("reset", obs(1'b1), expv(1'b0, 4'hF, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0));
        reset = 1'b0;
        @(negedge clk);
        chk("idle", obs(1'b1), expv(1'b0, 4'hF, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0));

        wr_req = 1'b1;
        run_write("wr", 1'b0, -1, 16'hC5A3);
        rd_req = 1'b1;
        run_read("rd", 1'b0, 2, 16'h4321, 4'hF, 1'b0);
        rd_req = 1'b1;
        run_read("rd_bad", 1'b0, 2, 16'h4321, 4'hE, 1'b0);
        rd_req = 1'b1;
        run_rd_timeout();

        // Reset during the second data nibble.
        @(negedge clk);
        wr_req = 1'b1;
        run_write("wr_abort", 1'b0, T + 2, 16'($urandom));
        @(negedge clk);
        chk("abort_rst", obs(1'b0), expv(1'b0, 4'hF, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0));
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("abort_idle[%0d]", i), obs(1'b0),
                expv(1'b0, 4'hF, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0));
        end
        wr_req = 1'b1;
        run_write("wr_after", 1'b0, -1, 16'($urandom));

        // Both requests held from reset: W, R, W.
        @(negedge clk);
        reset  = 1'b1;
        wr_req = 1'b1;
        rd_req = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        run_write("ct_w1", 1'b1, -1, 16'($urandom));
        run_read("ct_r", 1'b1, int'($urandom_range(0, 6)), 16'($urandom), 4'hF, 1'b1);
        run_write("ct_w2", 1'b0, -1, 16'($urandom));
        last_wr = 1'b1;

        for (int n = 0; n < 12; n++) begin
            r2 = 2'($urandom_range(1, 3));
            grant_wr = r2[0] && (!r2[1] || !last_wr);
            last_wr  = grant_wr;
            wr_req   = r2[0];
            rd_req   = r2[1];
            if (grant_wr) begin
                run_write($sformatf("rw%0d", n), 1'b0, -1, 16'($urandom));
            end else begin
                endn = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 14)) : 4'hF;
                run_read($sformatf("rr%0d", n), 1'b0, int'($urandom_range(0, 10)),
                         16'($urandom), endn, 1'b1);
            end
        end

        @(negedge clk);
        chk("final_idle", obs(1'b0), expv(1'b0, 4'hF, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
